// File: rtl/hwpe_buffer_arbiter_if.sv
// Requester-side and buffer-side signals of hwpe_buffer_arbiter.
// The slave modport is the arbiter's view; master is the surrounding engine/buffer.
interface hwpe_buffer_arbiter_if #(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned NumWords  = 128,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned AddrWidth = $clog2(NumWords);

    logic [NumPorts-1:0]                in_req_i;
    logic [NumPorts-1:0]                in_we_i;
    logic [NumPorts-1:0][AddrWidth-1:0] in_addr_i;
    logic [NumPorts-1:0][DataWidth-1:0] in_wdata_i;
    logic [NumPorts-1:0]                in_gnt_o;
    logic [NumPorts-1:0]                in_r_valid_o;
    logic [DataWidth-1:0]               in_r_data_o;

    logic                               buf_req_o;
    logic                               buf_we_o;
    logic [AddrWidth-1:0]               buf_addr_o;
    logic [DataWidth-1:0]               buf_wdata_o;
    logic [DataWidth-1:0]               buf_rdata_i;

    modport slave (
        input  in_req_i, in_we_i, in_addr_i, in_wdata_i, buf_rdata_i,
        output in_gnt_o, in_r_valid_o, in_r_data_o,
        output buf_req_o, buf_we_o, buf_addr_o, buf_wdata_o
    );

    modport master (
        output in_req_i, in_we_i, in_addr_i, in_wdata_i, buf_rdata_i,
        input  in_gnt_o, in_r_valid_o, in_r_data_o,
        input  buf_req_o, buf_we_o, buf_addr_o, buf_wdata_o
    );
endinterface

// File: rtl/hwpe_buffer_arbiter.sv
// Round-robin arbiter sharing one single-port hwpe_buffer among NumPorts requesters.
// Define HWPE_BUFFER_ARB_STALL_CNT_EN to add the saturating 32-bit stall_cnt_o output.
module hwpe_buffer_arbiter #(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned NumWords  = 128,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    hwpe_buffer_arbiter_if.slave bus
`ifdef HWPE_BUFFER_ARB_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);
    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned PtrWidth  = $clog2(NumPorts);

    logic [PtrWidth-1:0]  rr_q;
    logic [PtrWidth-1:0]  winner;
    logic [PtrWidth-1:0]  rr_next;
    logic [PtrWidth-1:0]  idx;
    logic                 any_req;
    logic                 rd_grant;
    logic [NumPorts-1:0]  gnt;
    logic [NumPorts-1:0]  r_valid_q;
    logic [DataWidth-1:0] r_data_q;

    // First requesting port at or after rr_q, wrapping upward.
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            idx = PtrWidth'((int'(rr_q) + i) % int'(NumPorts));
            if (!any_req && bus.in_req_i[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    assign rr_next = (winner == PtrWidth'(NumPorts - 1)) ? '0 : winner + PtrWidth'(1);

    always_comb begin
        gnt             = '0;
        bus.buf_req_o   = any_req;
        bus.buf_we_o    = 1'b0;
        bus.buf_addr_o  = '0;
        bus.buf_wdata_o = '0;
        if (any_req) begin
            gnt[winner]     = 1'b1;
            bus.buf_we_o    = bus.in_we_i[winner];
            bus.buf_addr_o  = bus.in_addr_i[winner];
            bus.buf_wdata_o = bus.in_wdata_i[winner];
        end
    end

    assign rd_grant         = any_req & ~bus.buf_we_o;
    assign bus.in_gnt_o     = gnt;
    assign bus.in_r_valid_o = r_valid_q;
    assign bus.in_r_data_o  = r_data_q;

    // A grant during clear_i still reaches the buffer, but its response is dropped.
    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else if (clear_i) begin
            rr_q      <= '0;
            r_valid_q <= '0;
        end else begin
            if (any_req) rr_q <= rr_next;
            r_valid_q <= rd_grant ? gnt : '0;
            if (rd_grant) r_data_q <= bus.buf_rdata_i;
        end
    end

`ifdef HWPE_BUFFER_ARB_STALL_CNT_EN
    logic [31:0] stall_q;
    logic [32:0] stall_sum;

    // One extra bit catches the wrap so the count saturates at all-ones.
    always_comb begin
        stall_sum = {1'b0, stall_q};
        for (int k = 0; k < int'(NumPorts); k++) begin
            stall_sum = stall_sum + 33'(bus.in_req_i[k] & ~gnt[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (clear_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_sum[32] ? '1 : stall_sum[31:0];
        end
    end

    assign stall_cnt_o = stall_q;
`else
    // Without the counter, arbitration keeps no extra state.
`endif
endmodule
